// File: rtl/ex_stage_ctrl.sv
// ----------------------------------------------------------------------------
// ex_stage_ctrl
//   Execute-stage control for the PA-RISC pipeline.
//   - ID/EX latch: registers decoded operands, ALU opcode and per-instruction
//     control bits (carry use, flag write, condition select/enable/negate).
//   - PSW: architectural {Z,N,C,V} flag register. Its carry feeds back as the
//     ALU carry-in for carry-using instructions.
//   - Condition unit: evaluates the nullify/compare condition on the live ALU
//     flags and result of the instruction currently in EX.
//   - EX/MEM latch: captures result, flags and condition outcome for MEM.
//
// Ports
//   clk, reset       single rising-edge clock, synchronous active-high reset
//   stall            freeze ID/EX, EX/MEM and PSW
//   flush            turn the instruction entering EX into a bubble
//   id_*             decoded instruction from ID
//   alu_out/flags    combinational ALU response to ex_a/ex_b/ex_op/ex_ci
//   ex_*             ALU drive and EX-stage valid
//   psw_flags        architectural {Z,N,C,V}
//   mem_*            EX/MEM latch contents
// ----------------------------------------------------------------------------
module ex_stage_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned COND_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [OP_W-1:0]   id_op,
  input  logic              id_use_c,
  input  logic              id_set_flags,
  input  logic              id_cond_en,
  input  logic [COND_W-1:0] id_cond,
  input  logic              id_cond_neg,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [OP_W-1:0]   ex_op,
  output logic              ex_ci,
  output logic              ex_valid,
  output logic [3:0]        psw_flags,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [3:0]        mem_flags,
  output logic              mem_nullify
);

  // Bit positions inside a {Z,N,C,V} flag vector.
  localparam int unsigned FZ = 3;
  localparam int unsigned FN = 2;
  localparam int unsigned FC = 1;
  localparam int unsigned FV = 0;

  // Condition selector encodings.
  localparam logic [COND_W-1:0] C_NEVER = COND_W'(0);
  localparam logic [COND_W-1:0] C_EQ    = COND_W'(1);
  localparam logic [COND_W-1:0] C_LT    = COND_W'(2);
  localparam logic [COND_W-1:0] C_LE    = COND_W'(3);
  localparam logic [COND_W-1:0] C_LTU   = COND_W'(4);
  localparam logic [COND_W-1:0] C_LEU   = COND_W'(5);
  localparam logic [COND_W-1:0] C_OV    = COND_W'(6);
  localparam logic [COND_W-1:0] C_ODD   = COND_W'(7);

  // ID/EX control latches.
  logic              ex_use_c;
  logic              ex_set_flags;
  logic              ex_cond_en;
  logic [COND_W-1:0] ex_cond;
  logic              ex_cond_neg;

  logic cond_hit;
  logic nullify_next;
  logic psw_we;

  // --------------------------------------------------------------------------
  // ID/EX latch: reset > flush > stall > load.
  // Flush leaves operands in place; only valid and control are cleared.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_op        <= '0;
      ex_use_c     <= 1'b0;
      ex_set_flags <= 1'b0;
      ex_cond_en   <= 1'b0;
      ex_cond      <= '0;
      ex_cond_neg  <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_op        <= '0;
      ex_use_c     <= 1'b0;
      ex_set_flags <= 1'b0;
      ex_cond_en   <= 1'b0;
      ex_cond      <= '0;
      ex_cond_neg  <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      ex_a         <= id_a;
      ex_b         <= id_b;
      ex_op        <= id_op;
      ex_use_c     <= id_use_c;
      ex_set_flags <= id_set_flags;
      ex_cond_en   <= id_cond_en;
      ex_cond      <= id_cond;
      ex_cond_neg  <= id_cond_neg;
    end
  end

  // Carry-in reads the PSW register directly: a flag-writing instruction
  // updates PSW on the same edge its successor enters EX, so ADD;ADDC
  // back-to-back sees the fresh carry without a bypass path.
  assign ex_ci = ex_use_c & psw_flags[FC];

  // --------------------------------------------------------------------------
  // Condition evaluation on live ALU flags/result.
  // --------------------------------------------------------------------------
  always_comb begin
    cond_hit = 1'b0;
    unique case (ex_cond)
      C_NEVER: cond_hit = 1'b0;
      C_EQ:    cond_hit = alu_flags[FZ];
      C_LT:    cond_hit = alu_flags[FN] ^ alu_flags[FV];
      C_LE:    cond_hit = (alu_flags[FN] ^ alu_flags[FV]) | alu_flags[FZ];
      C_LTU:   cond_hit = ~alu_flags[FC];
      C_LEU:   cond_hit = ~alu_flags[FC] | alu_flags[FZ];
      C_OV:    cond_hit = alu_flags[FV];
      C_ODD:   cond_hit = alu_out[0];
      default: cond_hit = 1'b0;
    endcase
  end

  // NEVER with negate gives ALWAYS.
  assign nullify_next = ex_valid & ex_cond_en & (cond_hit ^ ex_cond_neg);

  // --------------------------------------------------------------------------
  // EX/MEM latch: flush does not reach this stage; stall holds it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid   <= 1'b0;
      mem_result  <= '0;
      mem_flags   <= '0;
      mem_nullify <= 1'b0;
    end else if (!stall) begin
      mem_valid   <= ex_valid;
      mem_result  <= alu_out;
      mem_flags   <= alu_flags;
      mem_nullify <= nullify_next;
    end
  end

  // --------------------------------------------------------------------------
  // PSW: written only by a real, unstalled flag-setting instruction. Since EX
  // is frozen while stalled, an instruction writes PSW exactly once.
  // --------------------------------------------------------------------------
  assign psw_we = ex_valid & ex_set_flags & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      psw_flags <= '0;
    end else if (psw_we) begin
      psw_flags <= alu_flags;
    end
  end

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_stage_ctrl
//   Bench for ex_stage_ctrl. A small ALU model answers the DUT's ex_* drive.
//   A behavioural pipeline model (instruction records per stage, PSW value)
//   predicts every output; a compare process checks it on each falling edge.
//   Directed sequences pin literal values; a random phase follows.
// ----------------------------------------------------------------------------
module tb_ex_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        id_valid;
  logic [31:0] id_a, id_b;
  logic [3:0]  id_op;
  logic        id_use_c, id_set_flags, id_cond_en, id_cond_neg;
  logic [2:0]  id_cond;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;
  logic [31:0] ex_a, ex_b;
  logic [3:0]  ex_op;
  logic        ex_ci, ex_valid;
  logic [3:0]  psw_flags;
  logic        mem_valid;
  logic [31:0] mem_result;
  logic [3:0]  mem_flags;
  logic        mem_nullify;

  int n_pass  = 0;
  int n_total = 0;
  logic cmp_en = 1'b0;

  ex_stage_ctrl #(.DATA_W(32), .OP_W(4), .COND_W(3)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_a(id_a), .id_b(id_b), .id_op(id_op),
    .id_use_c(id_use_c), .id_set_flags(id_set_flags), .id_cond_en(id_cond_en),
    .id_cond(id_cond), .id_cond_neg(id_cond_neg),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op), .ex_ci(ex_ci), .ex_valid(ex_valid),
    .psw_flags(psw_flags), .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_flags(mem_flags), .mem_nullify(mem_nullify)
  );

  always #5 clk = ~clk;

  // ALU: 0 ADD(+ci), 1 SUB, 2 AND, 3 OR, 4 XOR, other PASS A.
  // Returns {Z,N,C,V, result}.
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op, input logic ci);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; s = '0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b} + {32'b0, ci};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = a;
    endcase
    return {(r == 32'd0), r[31], c, v, r};
  endfunction

  // Condition rules written from the architectural definitions.
  function automatic logic cond_f(input logic [3:0] f, input logic [31:0] r, input logic [2:0] sel);
    logic z, n, c, v;
    {z, n, c, v} = f;
    case (sel)
      3'd1:    return z;
      3'd2:    return n != v;
      3'd3:    return (n != v) || z;
      3'd4:    return !c;
      3'd5:    return !c || z;
      3'd6:    return v;
      3'd7:    return r[0];
      default: return 1'b0;
    endcase
  endfunction

  // Environment ALU responding to the DUT.
  always_comb {alu_flags, alu_out} = alu_f(ex_a, ex_b, ex_op, ex_ci);

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        uc, sf, ce;
    logic [2:0]  cond;
    logic        neg;
  } instr_t;

  instr_t      m_ex;
  logic [3:0]  m_psw;
  logic        m_mem_v, m_mem_null;
  logic [31:0] m_mem_res;
  logic [3:0]  m_mem_fl;
  logic [35:0] m_fr;
  logic        m_ci;
  instr_t      id_rec;

  assign m_ci   = m_ex.uc && m_psw[1];
  assign m_fr   = alu_f(m_ex.a, m_ex.b, m_ex.op, m_ci);
  assign id_rec = '{v: id_valid, a: id_a, b: id_b, op: id_op, uc: id_use_c, sf: id_set_flags,
                    ce: id_cond_en, cond: id_cond, neg: id_cond_neg};

  always @(posedge clk) begin
    if (reset) begin
      m_ex       <= '0;
      m_psw      <= '0;
      m_mem_v    <= 1'b0;
      m_mem_res  <= '0;
      m_mem_fl   <= '0;
      m_mem_null <= 1'b0;
    end else begin
      if (!stall) begin
        m_mem_v    <= m_ex.v;
        m_mem_res  <= m_fr[31:0];
        m_mem_fl   <= m_fr[35:32];
        m_mem_null <= m_ex.v && m_ex.ce && (cond_f(m_fr[35:32], m_fr[31:0], m_ex.cond) != m_ex.neg);
        if (m_ex.v && m_ex.sf) m_psw <= m_fr[35:32];
      end
      if (flush)       m_ex <= '{v: 1'b0, a: m_ex.a, b: m_ex.b, default: '0};
      else if (!stall) m_ex <= id_rec;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m.ex_valid",    32'(ex_valid),    32'(m_ex.v));
      chk("m.ex_ci",       32'(ex_ci),       32'(m_ci));
      chk("m.psw",         32'(psw_flags),   32'(m_psw));
      chk("m.mem_valid",   32'(mem_valid),   32'(m_mem_v));
      chk("m.mem_nullify", 32'(mem_nullify), 32'(m_mem_null));
      if (m_ex.v) begin
        chk("m.ex_a",  ex_a,         m_ex.a);
        chk("m.ex_b",  ex_b,         m_ex.b);
        chk("m.ex_op", 32'(ex_op),   32'(m_ex.op));
      end
      if (m_mem_v) begin
        chk("m.mem_result", mem_result,      m_mem_res);
        chk("m.mem_flags",  32'(mem_flags),  32'(m_mem_fl));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic uc, input logic sf,
                       input logic ce, input logic [2:0] c, input logic ng);
    id_valid = v; id_a = a; id_b = b; id_op = op; id_use_c = uc;
    id_set_flags = sf; id_cond_en = ce; id_cond = c; id_cond_neg = ng;
  endtask

  task automatic bubble();
    issue(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one instruction, let it reach MEM with a bubble behind it.
  task automatic run1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [2:0] c, input logic ng);
    issue(1'b1, a, b, op, 1'b0, 1'b0, 1'b1, c, ng);
    tick();
    bubble();
    tick();
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    // 1: reset held two cycles with a valid instruction presented
    issue(1'b1, 32'd5, 32'd7, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    tick();
    chk("rst.ex_valid",  32'(ex_valid),    32'd0);
    chk("rst.ex_a",      ex_a,             32'd0);
    chk("rst.ex_op",     32'(ex_op),       32'd0);
    chk("rst.mem_valid", 32'(mem_valid),   32'd0);
    chk("rst.mem_res",   mem_result,       32'd0);
    chk("rst.psw",       32'(psw_flags),   32'd0);
    chk("rst.null",      32'(mem_nullify), 32'd0);
    cmp_en = 1'b1;
    reset  = 1'b0;
    tick();
    bubble();
    tick();
    chk("add.result", mem_result,      32'd12);
    chk("add.valid",  32'(mem_valid),  32'd1);

    // 2: carry chain ADD then ADDC
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    issue(1'b1, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    chk("addc.psw", 32'(psw_flags), 32'b1010);
    chk("addc.ci",  32'(ex_ci),     32'd1);
    bubble();
    tick();
    chk("addc.result", mem_result, 32'd1);

    // 3: conditions
    run1(32'd3, 32'd5, 4'd1, 3'd2, 1'b0);
    chk("cond.lt",    32'(mem_nullify), 32'd1);
    run1(32'd3, 32'd5, 4'd1, 3'd2, 1'b1);
    chk("cond.ltneg", 32'(mem_nullify), 32'd0);
    run1(32'd4, 32'd4, 4'd1, 3'd1, 1'b0);
    chk("cond.eq",    32'(mem_nullify), 32'd1);
    run1(32'd3, 32'd4, 4'd0, 3'd7, 1'b0);
    chk("cond.odd",   32'(mem_nullify), 32'd1);

    // 4: flush of a flag-setting ADD
    issue(1'b1, 32'd1, 32'd1, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    flush = 1'b1;
    tick();
    chk("flush.ex_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0;
    bubble();
    tick();
    chk("flush.mem_valid", 32'(mem_valid), 32'd0);
    chk("flush.psw",       32'(psw_flags), 32'b1010);

    // 5: three-cycle stall with ADD 2+3 in EX
    issue(1'b1, 32'd2, 32'd3, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    stall = 1'b1;
    issue(1'b1, 32'd9, 32'd9, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.ex_a",      ex_a,            32'd2);
      chk("stall.mem_valid", 32'(mem_valid),  32'd0);
      chk("stall.psw",       32'(psw_flags),  32'b1010);
    end
    stall = 1'b0;
    bubble();
    tick();
    chk("stall.result", mem_result,     32'd5);
    chk("stall.mvalid", 32'(mem_valid), 32'd1);
    chk("stall.psw2",   32'(psw_flags), 32'b0000);
    tick();
    chk("stall.once",   32'(mem_valid), 32'd0);

    // 6: reset with both latches occupied
    issue(1'b1, 32'd3, 32'd5, 4'd1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
    tick();
    issue(1'b1, 32'd4, 32'd4, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    chk("r6.null_pre", 32'(mem_nullify), 32'd1);
    chk("r6.psw_pre",  32'(psw_flags),   32'b0100);
    reset = 1'b1;
    tick();
    chk("r6.ex_valid",  32'(ex_valid),    32'd0);
    chk("r6.mem_valid", 32'(mem_valid),   32'd0);
    chk("r6.psw",       32'(psw_flags),   32'd0);
    chk("r6.null",      32'(mem_nullify), 32'd0);
    reset = 1'b0;

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      issue(($urandom_range(0, 3) != 0), rand_opnd(), rand_opnd(), 4'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tick();
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
